// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 control unit:
// FSM states, instruction classes, ALU op codes, opcode/funct fields and operand-2 selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        DECODE,
        EXEC,
        WB,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_DIV = 3'b100;

    localparam logic [1:0] OP2_RS2  = 2'b00;
    localparam logic [1:0] OP2_UIMM = 2'b01;
    localparam logic [1:0] OP2_IIMM = 2'b10;
    localparam logic [1:0] OP2_SIMM = 2'b11;

    typedef struct packed {
        logic ram_cs;
        logic ram_we;
        logic ram_oe;
        logic pc_en;
        logic ir_en;
        logic reg_en;
        logic reg_we;
        logic reg_in_dir;
        logic alu_en;
    } ctrl_out_t;

    function automatic logic uses_alu(input state_t s);
        return (s == EXEC) || (s == MEM_ADDR) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

    function automatic logic is_access(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

    // Moore output map; everything not named for a state stays low.
    function automatic ctrl_out_t moore_out(input state_t s, input logic load);
        ctrl_out_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.ram_cs = 1'b1;
                o.ram_oe = 1'b1;
            end
            LATCH: begin
                o.ir_en = 1'b1;
                o.pc_en = 1'b1;
            end
            EXEC, MEM_ADDR: o.alu_en = 1'b1;
            WB: begin
                o.reg_en     = 1'b1;
                o.reg_we     = 1'b1;
                o.reg_in_dir = load;
            end
            MEM_RD: begin
                o.ram_cs = 1'b1;
                o.ram_oe = 1'b1;
                o.alu_en = 1'b1;
            end
            MEM_WR: begin
                o.ram_cs = 1'b1;
                o.ram_we = 1'b1;
                o.alu_en = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32 instruction decoder: class, ALU op and operand-2 select.
// MUL/DIV decode is present only when CTRL_MULDIV_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 8
) (
    input  logic [31:0]         instr,
    output instr_class_t        iclass,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] op_code;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        iclass  = CLS_ILLEGAL;
        op_code = OP_ADD;
        op2_dir = OP2_RS2;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    iclass = CLS_ALU;
                    case (funct3)
                        F3_ADD:  op_code = OP_ADD;
                        F3_SLL:  op_code = OP_SLL;
                        F3_SRL:  op_code = OP_SRL;
                        F3_XOR:  op_code = OP_XOR;
                        F3_OR:   op_code = OP_OR;
                        F3_AND:  op_code = OP_AND;
                        default: iclass  = CLS_ILLEGAL;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    iclass  = CLS_ALU;
                    op_code = OP_SUB;
`ifdef CTRL_MULDIV_EN
                end else if (funct7 == F7_MULDIV && funct3 == F3_MUL) begin
                    iclass  = CLS_ALU;
                    op_code = OP_MUL;
                end else if (funct7 == F7_MULDIV && funct3 == F3_DIV) begin
                    iclass  = CLS_ALU;
                    op_code = OP_DIV;
`endif
                end else begin
                    iclass = CLS_ILLEGAL;
                end
            end
            OPC_OP_IMM: begin
                iclass  = CLS_ALU;
                op2_dir = OP2_IIMM;
                case (funct3)
                    F3_ADD:  op_code = OP_ADDI;
                    F3_XOR:  op_code = OP_XOR;
                    F3_OR:   op_code = OP_OR;
                    F3_AND:  op_code = OP_AND;
                    default: iclass  = CLS_ILLEGAL;
                endcase
            end
            OPC_LUI: begin
                iclass  = CLS_LUI;
                op_code = OP_LUI;
                op2_dir = OP2_UIMM;
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    iclass  = CLS_LOAD;
                    op_code = OP_ADDI;
                    op2_dir = OP2_IIMM;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    iclass  = CLS_STORE;
                    op_code = OP_ADDI;
                    op2_dir = OP2_SIMM;
                end
            end
            default: iclass = CLS_ILLEGAL;
        endcase
        // Illegal encodings leave nothing half-decoded behind in the registers.
        if (iclass == CLS_ILLEGAL) begin
            op_code = OP_ADD;
            op2_dir = OP2_RS2;
        end
    end

    assign alu_op = ALU_OP_W'(op_code);

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM for the RV32 teaching CPU with RAM-ready timeout and sticky traps.
// Define CTRL_MULDIV_EN to accept MUL/DIV encodings (handled inside ctrl_decode).
module ctrl_mc
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 8,
    parameter int RAM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                ram_ready,
    output logic                ram_cs,
    output logic                ram_we,
    output logic                ram_oe,
    output logic                pc_en,
    output logic                pc_in_dir,
    output logic                pc_sign,
    output logic                ir_en,
    output logic                reg_en,
    output logic                reg_we,
    output logic                reg_in_dir,
    output logic                alu_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir,
    output logic                illegal,
    output logic                bus_err
);

    localparam int CNT_W = (RAM_WAIT_MAX > 0) ? $clog2(RAM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RAM_WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    state_t                state, next_state;
    logic [CNT_W-1:0]      wait_cnt, next_cnt;
    logic [ALU_OP_W-1:0]   alu_op_q, next_alu_op;
    logic [1:0]            op2_q, next_op2;
    logic                  is_load_q, next_is_load;
    logic                  next_illegal, next_bus_err;
    ctrl_out_t             out_q;

    instr_class_t          dec_class;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic [1:0]            dec_op2;

    ctrl_decode #(
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .instr    (instr),
        .iclass   (dec_class),
        .alu_op   (dec_alu_op),
        .op2_dir  (dec_op2)
    );

    always_comb begin
        next_state   = state;
        next_cnt     = wait_cnt;
        next_alu_op  = alu_op_q;
        next_op2     = op2_q;
        next_is_load = is_load_q;
        next_illegal = illegal;
        next_bus_err = bus_err;
        case (state)
            IDLE: next_state = FETCH;
            FETCH, MEM_RD, MEM_WR: begin
                // Ready is checked first so a response on the final allowed cycle still completes.
                if (ram_ready) begin
                    if (state == FETCH)
                        next_state = LATCH;
                    else if (state == MEM_RD)
                        next_state = WB;
                    else
                        next_state = FETCH;
                end else if (RAM_WAIT_MAX != 0 && wait_cnt == CNT_LIMIT) begin
                    next_state   = TRAP;
                    next_bus_err = 1'b1;
                end else if (wait_cnt != CNT_SAT) begin
                    next_cnt = wait_cnt + CNT_W'(1);
                end
            end
            LATCH: next_state = DECODE;
            DECODE: begin
                next_alu_op  = dec_alu_op;
                next_op2     = dec_op2;
                next_is_load = (dec_class == CLS_LOAD);
                case (dec_class)
                    CLS_ALU, CLS_LUI:    next_state = EXEC;
                    CLS_LOAD, CLS_STORE: next_state = MEM_ADDR;
                    default: begin
                        next_state   = TRAP;
                        next_illegal = 1'b1;
                    end
                endcase
            end
            EXEC:     next_state = WB;
            WB:       next_state = FETCH;
            MEM_ADDR: next_state = is_load_q ? MEM_RD : MEM_WR;
            TRAP:     next_state = TRAP;
            default:  next_state = IDLE;
        endcase
        if (next_state != state && is_access(next_state))
            next_cnt = '0;
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            alu_op_q  <= '0;
            op2_q     <= OP2_RS2;
            is_load_q <= 1'b0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
            out_q     <= '0;
            alu_op    <= '0;
            op2_dir   <= OP2_RS2;
        end else begin
            state     <= next_state;
            wait_cnt  <= next_cnt;
            alu_op_q  <= next_alu_op;
            op2_q     <= next_op2;
            is_load_q <= next_is_load;
            illegal   <= next_illegal;
            bus_err   <= next_bus_err;
            out_q     <= moore_out(next_state, next_is_load);
            alu_op    <= uses_alu(next_state) ? next_alu_op : '0;
            op2_dir   <= uses_alu(next_state) ? next_op2 : OP2_RS2;
        end
    end

    assign ram_cs     = out_q.ram_cs;
    assign ram_we     = out_q.ram_we;
    assign ram_oe     = out_q.ram_oe;
    assign pc_en      = out_q.pc_en;
    assign ir_en      = out_q.ir_en;
    assign reg_en     = out_q.reg_en;
    assign reg_we     = out_q.reg_we;
    assign reg_in_dir = out_q.reg_in_dir;
    assign alu_en     = out_q.alu_en;
    assign pc_in_dir  = 1'b0;
    assign pc_sign    = 1'b0;

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: stimulus queues hand-computed per-cycle outputs, a negedge monitor compares.
module tb_ctrl_mc;

    localparam int WAIT_MAX = 4;

    typedef struct packed {
        logic       ram_cs;
        logic       ram_we;
        logic       ram_oe;
        logic       pc_en;
        logic       pc_in_dir;
        logic       pc_sign;
        logic       ir_en;
        logic       reg_en;
        logic       reg_we;
        logic       reg_in_dir;
        logic       alu_en;
        logic [7:0] alu_op;
        logic [1:0] op2_dir;
        logic       illegal;
        logic       bus_err;
    } obs_t;

    // Control bit order: cs we oe pc_en pc_in_dir pc_sign ir_en reg_en reg_we reg_in_dir alu_en
    localparam logic [10:0] C_NONE  = 11'b00000000000;
    localparam logic [10:0] C_FETCH = 11'b10100000000;
    localparam logic [10:0] C_LATCH = 11'b00010010000;
    localparam logic [10:0] C_EXEC  = 11'b00000000001;
    localparam logic [10:0] C_WB    = 11'b00000001100;
    localparam logic [10:0] C_WB_LW = 11'b00000001110;
    localparam logic [10:0] C_MRD   = 11'b10100000001;
    localparam logic [10:0] C_MWR   = 11'b11000000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    logic       ram_cs, ram_we, ram_oe, pc_en, pc_in_dir, pc_sign, ir_en;
    logic       reg_en, reg_we, reg_in_dir, alu_en, illegal, bus_err;
    logic [7:0] alu_op;
    logic [1:0] op2_dir;

    obs_t  got;
    obs_t  exp_q[$];
    string name_q[$];
    int    n_compared = 0;
    int    n_mismatch = 0;

    ctrl_mc #(
        .ALU_OP_W     (8),
        .RAM_WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .ram_ready  (ram_ready),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_oe     (ram_oe),
        .pc_en      (pc_en),
        .pc_in_dir  (pc_in_dir),
        .pc_sign    (pc_sign),
        .ir_en      (ir_en),
        .reg_en     (reg_en),
        .reg_we     (reg_we),
        .reg_in_dir (reg_in_dir),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .op2_dir    (op2_dir),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    assign got = {ram_cs, ram_we, ram_oe, pc_en, pc_in_dir, pc_sign, ir_en,
                  reg_en, reg_we, reg_in_dir, alu_en, alu_op, op2_dir, illegal, bus_err};

    function automatic obs_t mk(input logic [10:0] ctl, input logic [7:0] op,
                                input logic [1:0] o2, input logic [1:0] flags);
        return obs_t'({ctl, op, o2, flags});
    endfunction

    task automatic checkOutput(input string n, input obs_t e);
        n_compared++;
        if (got !== e) begin
            n_mismatch++;
            $display("[TB] FAIL %s: actual %b required %b", n, got, e);
        end
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checkOutput(n, e);
        end
    end

    task automatic push(input string n, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic applyStimulus(input string n, input logic rdy, input obs_t e);
        @(posedge clk);
        #1;
        ram_ready = rdy;
        push(n, e);
    endtask

    // Reset is raised between edges so the asynchronous clear is visible before the next edge.
    task automatic applyReset(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        ram_ready = 1'b0;
        push({tag, "_asserted"}, mk(C_NONE, 8'd0, 2'b00, 2'b00));
        @(posedge clk);
        #1;
        rst = 1'b0;
        push({tag, "_idle"}, mk(C_NONE, 8'd0, 2'b00, 2'b00));
    endtask

    task automatic runAlu(input string tag, input logic [31:0] ins,
                          input logic [7:0] op, input logic [1:0] o2);
        instr = ins;
        applyStimulus({tag, "_fetch"},  1'b1, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus({tag, "_latch"},  1'b1, mk(C_LATCH, 8'd0, 2'b00, 2'b00));
        applyStimulus({tag, "_decode"}, 1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b00));
        applyStimulus({tag, "_exec"},   1'b1, mk(C_EXEC,  op,   o2,    2'b00));
        applyStimulus({tag, "_wb"},     1'b1, mk(C_WB,    8'd0, 2'b00, 2'b00));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset("rst_a");

        runAlu("add",  32'h002081B3, 8'd0, 2'b00);
        runAlu("addi", 32'h00500093, 8'd1, 2'b10);

        // LUI with fetch answering on the last allowed wait cycle.
        instr = 32'h123452B7;
        for (int i = 0; i < WAIT_MAX; i++)
            applyStimulus("lui_fetch_wait", 1'b0, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("lui_fetch_ready", 1'b1, mk(C_FETCH, 8'd0,  2'b00, 2'b00));
        applyStimulus("lui_latch",       1'b1, mk(C_LATCH, 8'd0,  2'b00, 2'b00));
        applyStimulus("lui_decode",      1'b1, mk(C_NONE,  8'd0,  2'b00, 2'b00));
        applyStimulus("lui_exec",        1'b1, mk(C_EXEC,  8'd11, 2'b01, 2'b00));
        applyStimulus("lui_wb",          1'b1, mk(C_WB,    8'd0,  2'b00, 2'b00));

        // LW x1,0(x2) with three wait cycles in MEM_RD.
        instr = 32'h00012083;
        applyStimulus("lw_fetch",  1'b1, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("lw_latch",  1'b0, mk(C_LATCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("lw_decode", 1'b0, mk(C_NONE,  8'd0, 2'b00, 2'b00));
        applyStimulus("lw_addr",   1'b0, mk(C_EXEC,  8'd1, 2'b10, 2'b00));
        for (int i = 0; i < 3; i++)
            applyStimulus("lw_rd_wait", 1'b0, mk(C_MRD, 8'd1, 2'b10, 2'b00));
        applyStimulus("lw_rd_done", 1'b1, mk(C_MRD,   8'd1, 2'b10, 2'b00));
        applyStimulus("lw_wb",      1'b1, mk(C_WB_LW, 8'd0, 2'b00, 2'b00));

        // SW x1,4(x2) returns straight to FETCH.
        instr = 32'h00112223;
        applyStimulus("sw_fetch",  1'b1, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("sw_latch",  1'b1, mk(C_LATCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("sw_decode", 1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b00));
        applyStimulus("sw_addr",   1'b1, mk(C_EXEC,  8'd1, 2'b11, 2'b00));
        applyStimulus("sw_wr",     1'b1, mk(C_MWR,   8'd1, 2'b11, 2'b00));

        // Second LW, interrupted by reset inside MEM_RD.
        instr = 32'h00012083;
        applyStimulus("sw_then_fetch", 1'b1, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("lw2_latch",     1'b1, mk(C_LATCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("lw2_decode",    1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b00));
        applyStimulus("lw2_addr",      1'b0, mk(C_EXEC,  8'd1, 2'b10, 2'b00));
        applyStimulus("lw2_rd",        1'b0, mk(C_MRD,   8'd1, 2'b10, 2'b00));
        applyReset("rst_mid_memrd");

        // Fetch never answered: WAIT_MAX+1 fetch cycles, then bus-error trap.
        instr = 32'h002081B3;
        for (int i = 0; i <= WAIT_MAX; i++)
            applyStimulus("timeout_fetch", 1'b0, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("timeout_trap",      1'b1, mk(C_NONE, 8'd0, 2'b00, 2'b01));
        applyStimulus("timeout_trap_hold", 1'b1, mk(C_NONE, 8'd0, 2'b00, 2'b01));

        applyReset("rst_b");
        instr = 32'hFFFFFFFF;
        applyStimulus("ill_fetch",     1'b1, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("ill_latch",     1'b1, mk(C_LATCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("ill_decode",    1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b00));
        applyStimulus("ill_trap",      1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b10));
        applyStimulus("ill_trap_hold", 1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b10));

        applyReset("rst_c");
`ifdef CTRL_MULDIV_EN
        runAlu("mul", 32'h022081B3, 8'd3, 2'b00);
`else
        instr = 32'h022081B3;
        applyStimulus("mul_fetch",  1'b1, mk(C_FETCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("mul_latch",  1'b1, mk(C_LATCH, 8'd0, 2'b00, 2'b00));
        applyStimulus("mul_decode", 1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b00));
        applyStimulus("mul_trap",   1'b1, mk(C_NONE,  8'd0, 2'b00, 2'b10));
`endif

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_mismatch++;
            $display("[TB] FAIL drain: actual %0d pending required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
